observer_scan_ctrl: RTL and testbench
=====================================

// Module: observer_scan_ctrl
// PURPOSE
// Sequencer in front of the debug observer. It drives the observer's mode/register-select
// inputs and captures the returned 32-bit data word into a stable snapshot for the display.
// Two sources: manual (select taken from board switches, captured on a step button) and
// scan (walks a fixed 22-entry table, advanced by a dwell timer or by single steps).
// PARAMETERS
// SETTLE_CYCLES  2           cycles the select is held before capture (>=1)
// DWELL_CYCLES   50_000_000  hold time between auto-scan entries (>=1)
// CNT_W          26          width of the shared settle/dwell counter
// PORTS
// clk           in   1   system clock
// rst_n         in   1   asynchronous active-low reset
// manual_i      in   1   1 = manual source, 0 = scan table
// run_i         in   1   scan only: 1 = timer-driven advance, 0 = advance on step
// step_i        in   1   raw button, asynchronous to clk
// mode_req_i    in   3   manual mode request
// sel_req_i     in   4   manual register-select request
// obs_data_i    in   32  observer data output
// obs_mode_o    out  3   to observer mode input
// obs_sel_o     out  4   to observer select input
// snap_data_o   out  32  captured word
// snap_mode_o   out  3   mode of the captured word
// snap_sel_o    out  4   select of the captured word
// snap_valid_o  out  1   one-cycle pulse, snapshot updated
// scan_idx_o    out  5   current scan-table index, 0..21
// sweep_done_o  out  1   one-cycle pulse when the index wraps 21->0
// sweep_sum_o   out  32  XOR checksum of the last full sweep (optional feature)
// BEHAVIOUR
// - Reset: state IDLE; idx=0; all outputs 0; the synchronizer and counters are cleared.
// - step_i passes through a 2-flop synchronizer. The trigger is a rising edge of the
//   synchronized signal (one pulse per press). Edges outside IDLE are dropped.
// - Scan table by idx:
//   - 0..15  -> mode 0, sel = idx
//   - 16     -> mode 1, sel 0
//   - 17..19 -> mode 2, sel 1..3
//   - 20,21  -> mode 3, sel 14,15
// - manual_i and run_i are sampled only in IDLE. Changes mid-sequence apply at the next IDLE.
// - FSM, all transitions on clk:
//   - IDLE: trigger is the step edge (manual, or scan with run_i=0) or immediate (scan with
//     run_i=1). On trigger, load obs_mode_o/obs_sel_o from the requests (manual) or from the
//     table[idx] (scan), load the counter, and go to SETTLE.
//   - SETTLE: hold the select for SETTLE_CYCLES cycles, then go to CAPTURE.
//   - CAPTURE: for one cycle, register obs_data_i/obs_mode_o/obs_sel_o into the snap_*
//     outputs. snap_valid_o is high in the following cycle. In scan, idx = (idx==21) ? 0 :
//     idx+1, and the wrap pulses sweep_done_o in the same cycle as snap_valid_o. Go to DWELL
//     if scan and run, else go to IDLE.
//   - DWELL: count DWELL_CYCLES cycles, then go to IDLE. If run_i drops, go to IDLE at once.
// - Auto-scan period is 1 + SETTLE_CYCLES + 1 + DWELL_CYCLES cycles per entry.
// - obs_mode_o/obs_sel_o hold their last value outside SETTLE/CAPTURE. They never glitch.
// - Manual captures leave idx unchanged.
// - The counter saturates and never wraps. CNT_W must hold max(SETTLE, DWELL).
// - Asserting rst_n mid-sequence aborts immediately. No partial snapshot is produced.
// CONFIGURATION
// - OBS_SCAN_CHECKSUM_EN defined:
//   - A 32-bit accumulator XORs each scan-mode captured word.
//   - On wrap, sweep_sum_o takes accumulator^current word, and the accumulator clears.
//   - Manual captures do not affect it. Reset clears both.
// - OBS_SCAN_CHECKSUM_EN undefined: no accumulator logic; sweep_sum_o is tied to 32'h0.
// TESTING (SETTLE_CYCLES=2, DWELL_CYCLES=4)
// - Reset with all inputs at 0, no activity for 20 cycles -> all outputs 0, state IDLE.
// - manual_i=1, mode_req=3, sel_req=14, obs_data=32'h0000_0040, one step press ->
//   exactly one snap_valid_o pulse; snap_data=32'h40, snap_mode=3, snap_sel=14; idx stays 0.
// - manual_i=0, run_i=1, obs_data driven as {mode,sel} pattern -> snap_valid_o every 8
//   cycles; sequence (0,0)..(0,15),(1,0),(2,1..3),(3,14),(3,15); sweep_done_o pulses with
//   the 22nd capture, then idx=0.
// - run_i=0, step held high for 100 cycles -> one capture only. Three presses -> idx=3.
// - run_i dropped during DWELL -> IDLE next cycle, no further captures without a step.
// - rst_n pulsed low during SETTLE -> outputs 0 asynchronously; no snap_valid_o; after
//   release, auto-scan restarts at idx 0.
// - OBS_SCAN_CHECKSUM_EN: obs_data=32'h1 for all 22 entries -> sweep_sum_o=0 after wrap;
//   idx 0 = 32'hA5 and all others 0 -> 32'hA5. Macro undefined -> sweep_sum_o stays 0.

Source files
------------

// File: rtl/observer_scan_ctrl.sv
// observer_scan_ctrl
// Sequencer in front of the debug observer. It drives the observer's mode and
// register-select inputs, waits for the select to settle, and captures the
// returned 32-bit word into a stable snapshot for the display. There are two
// sources. In manual mode the select comes from the board switches and is
// captured on a step press. In scan mode the block walks a fixed 22-entry table,
// advanced either by a dwell timer (run_i=1) or by single step presses.
//
// Ports:
//   clk, rst_n                  system clock, async active-low reset
//   manual_i, run_i             source / advance selection (sampled in IDLE only)
//   step_i                      raw step button, asynchronous to clk
//   mode_req_i, sel_req_i       manual mode / register-select request
//   obs_data_i                  observer data word
//   obs_mode_o, obs_sel_o       drive to the observer
//   snap_data/mode/sel_o        captured word and the select it came from
//   snap_valid_o                one-cycle pulse, snapshot updated
//   scan_idx_o                  current scan-table index, 0..21
//   sweep_done_o                one-cycle pulse when the index wraps 21->0
//   sweep_sum_o                 XOR checksum of the last full sweep
//
// Build option: define OBS_SCAN_CHECKSUM_EN to enable the sweep checksum
// accumulator; otherwise sweep_sum_o is tied to zero.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for a trigger; obs_mode/obs_sel hold last value
// SETTLE   | select applied, counting SETTLE_CYCLES before the capture
// CAPTURE  | obs_data_i registered into the snapshot at the end of this cycle
// DWELL    | auto-scan hold between entries, DWELL_CYCLES long

module observer_scan_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned DWELL_CYCLES  = 50_000_000,
  parameter int unsigned CNT_W         = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        manual_i,
  input  logic        run_i,
  input  logic        step_i,
  input  logic [2:0]  mode_req_i,
  input  logic [3:0]  sel_req_i,
  input  logic [31:0] obs_data_i,
  output logic [2:0]  obs_mode_o,
  output logic [3:0]  obs_sel_o,
  output logic [31:0] snap_data_o,
  output logic [2:0]  snap_mode_o,
  output logic [3:0]  snap_sel_o,
  output logic        snap_valid_o,
  output logic [4:0]  scan_idx_o,
  output logic        sweep_done_o,
  output logic [31:0] sweep_sum_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DWELL   = 2'd3
  } state_t;

  // Down-counter reload values: terminal count is zero, so load N-1.
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_LOAD  = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [4:0]       LAST_IDX    = 5'd21;

  function automatic logic [6:0] scan_entry(input logic [4:0] idx);
    logic [6:0] e;
    case (idx)
      5'd16:               e = {3'd1, 4'd0};
      5'd17, 5'd18, 5'd19: e = {3'd2, idx[3:0]};
      5'd20:               e = {3'd3, 4'd14};
      5'd21:               e = {3'd3, 4'd15};
      default:             e = {3'd0, idx[3:0]};
    endcase
    return e;
  endfunction

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [4:0]        idx_q, idx_d;
  logic              manual_q, manual_d;
  logic              run_q, run_d;
  logic [2:0]        obs_mode_q, obs_mode_d;
  logic [3:0]        obs_sel_q, obs_sel_d;
  logic [31:0]       snap_data_q, snap_data_d;
  logic [2:0]        snap_mode_q, snap_mode_d;
  logic [3:0]        snap_sel_q, snap_sel_d;
  logic              snap_valid_q, snap_valid_d;
  logic              sweep_done_q, sweep_done_d;
  logic              step_meta_q, step_meta_d;
  logic              step_sync_q, step_sync_d;
  logic              step_prev_q, step_prev_d;
  logic              step_edge;
  logic              trigger;
  logic              wrap;
  logic [6:0]        entry;
`ifdef OBS_SCAN_CHECKSUM_EN
  logic [31:0]       acc_q, acc_d;
  logic [31:0]       sum_q, sum_d;
`endif

  assign step_edge = step_sync_q & ~step_prev_q;
  assign entry     = scan_entry(idx_q);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    manual_d     = manual_q;
    run_d        = run_q;
    obs_mode_d   = obs_mode_q;
    obs_sel_d    = obs_sel_q;
    snap_data_d  = snap_data_q;
    snap_mode_d  = snap_mode_q;
    snap_sel_d   = snap_sel_q;
    snap_valid_d = 1'b0;
    sweep_done_d = 1'b0;
    step_meta_d  = step_i;
    step_sync_d  = step_meta_q;
    // Edges seen outside IDLE are simply never consumed, i.e. dropped.
    step_prev_d  = step_sync_q;
    trigger      = 1'b0;
    wrap         = 1'b0;
`ifdef OBS_SCAN_CHECKSUM_EN
    acc_d        = acc_q;
    sum_d        = sum_q;
`endif

    case (state_q)
      ST_IDLE: begin
        trigger = (manual_i || !run_i) ? step_edge : 1'b1;
        if (trigger) begin
          manual_d = manual_i;
          run_d    = run_i;
          if (manual_i) begin
            obs_mode_d = mode_req_i;
            obs_sel_d  = sel_req_i;
          end else begin
            obs_mode_d = entry[6:4];
            obs_sel_d  = entry[3:0];
          end
          cnt_d   = SETTLE_LOAD;
          state_d = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (cnt_q == '0) state_d = ST_CAPTURE;
        else             cnt_d   = cnt_q - 1'b1;
      end

      ST_CAPTURE: begin
        snap_data_d  = obs_data_i;
        snap_mode_d  = obs_mode_q;
        snap_sel_d   = obs_sel_q;
        snap_valid_d = 1'b1;
        if (!manual_q) begin
          wrap         = (idx_q == LAST_IDX);
          idx_d        = wrap ? 5'd0 : idx_q + 5'd1;
          sweep_done_d = wrap;
`ifdef OBS_SCAN_CHECKSUM_EN
          if (wrap) begin
            sum_d = acc_q ^ obs_data_i;
            acc_d = '0;
          end else begin
            acc_d = acc_q ^ obs_data_i;
          end
`endif
        end
        cnt_d   = DWELL_LOAD;
        state_d = (!manual_q && run_q) ? ST_DWELL : ST_IDLE;
      end

      ST_DWELL: begin
        // run_i is watched live here so dropping it ends the hold immediately.
        if (!run_i || cnt_q == '0) state_d = ST_IDLE;
        else                       cnt_d   = cnt_q - 1'b1;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      manual_q     <= 1'b0;
      run_q        <= 1'b0;
      obs_mode_q   <= '0;
      obs_sel_q    <= '0;
      snap_data_q  <= '0;
      snap_mode_q  <= '0;
      snap_sel_q   <= '0;
      snap_valid_q <= 1'b0;
      sweep_done_q <= 1'b0;
      step_meta_q  <= 1'b0;
      step_sync_q  <= 1'b0;
      step_prev_q  <= 1'b0;
`ifdef OBS_SCAN_CHECKSUM_EN
      acc_q        <= '0;
      sum_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      manual_q     <= manual_d;
      run_q        <= run_d;
      obs_mode_q   <= obs_mode_d;
      obs_sel_q    <= obs_sel_d;
      snap_data_q  <= snap_data_d;
      snap_mode_q  <= snap_mode_d;
      snap_sel_q   <= snap_sel_d;
      snap_valid_q <= snap_valid_d;
      sweep_done_q <= sweep_done_d;
      step_meta_q  <= step_meta_d;
      step_sync_q  <= step_sync_d;
      step_prev_q  <= step_prev_d;
`ifdef OBS_SCAN_CHECKSUM_EN
      acc_q        <= acc_d;
      sum_q        <= sum_d;
`endif
    end
  end

  assign obs_mode_o   = obs_mode_q;
  assign obs_sel_o    = obs_sel_q;
  assign snap_data_o  = snap_data_q;
  assign snap_mode_o  = snap_mode_q;
  assign snap_sel_o   = snap_sel_q;
  assign snap_valid_o = snap_valid_q;
  assign scan_idx_o   = idx_q;
  assign sweep_done_o = sweep_done_q;
`ifdef OBS_SCAN_CHECKSUM_EN
  assign sweep_sum_o  = sum_q;
`else
  assign sweep_sum_o  = 32'h0;
`endif

endmodule

// File: tb/tb_observer_scan_ctrl.sv
// Testbench for observer_scan_ctrl with SETTLE_CYCLES=2, DWELL_CYCLES=4.
// Expected snapshots are pushed to a queue when stimulus is applied and popped
// whenever the DUT pulses snap_valid_o.

module tb_observer_scan_ctrl;

`ifdef OBS_SCAN_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        manual_i;
  logic        run_i;
  logic        step_i;
  logic [2:0]  mode_req_i;
  logic [3:0]  sel_req_i;
  logic [31:0] obs_data_i;
  logic [2:0]  obs_mode_o;
  logic [3:0]  obs_sel_o;
  logic [31:0] snap_data_o;
  logic [2:0]  snap_mode_o;
  logic [3:0]  snap_sel_o;
  logic        snap_valid_o;
  logic [4:0]  scan_idx_o;
  logic        sweep_done_o;
  logic [31:0] sweep_sum_o;

  observer_scan_ctrl #(
    .SETTLE_CYCLES(2),
    .DWELL_CYCLES (4),
    .CNT_W        (26)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .manual_i    (manual_i),
    .run_i       (run_i),
    .step_i      (step_i),
    .mode_req_i  (mode_req_i),
    .sel_req_i   (sel_req_i),
    .obs_data_i  (obs_data_i),
    .obs_mode_o  (obs_mode_o),
    .obs_sel_o   (obs_sel_o),
    .snap_data_o (snap_data_o),
    .snap_mode_o (snap_mode_o),
    .snap_sel_o  (snap_sel_o),
    .snap_valid_o(snap_valid_o),
    .scan_idx_o  (scan_idx_o),
    .sweep_done_o(sweep_done_o),
    .sweep_sum_o (sweep_sum_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observer stand-in: 0 = fixed word, 1 = {mode,sel} pattern, 2 = 0xA5 at (0,0) only.
  int          pat_sel;
  logic [31:0] obs_fixed;
  always_comb begin
    obs_data_i = obs_fixed;
    if (pat_sel == 1)      obs_data_i = {25'd0, obs_mode_o, obs_sel_o};
    else if (pat_sel == 2) obs_data_i = (obs_mode_o == 3'd0 && obs_sel_o == 4'd0) ? 32'hA5 : 32'h0;
  end

  typedef struct {
    logic [31:0] data;
    logic [2:0]  mode;
    logic [3:0]  sel;
    logic        done;
    logic [31:0] sum;
  } exp_t;

  exp_t        sb[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  int          n_cap    = 0;
  int          cyc      = 0;
  int          cap_cyc  = 0;
  int          last_cap = -1;
  int          m_idx    = 0;
  logic [31:0] m_acc    = 0;
  logic [31:0] m_sum    = 0;

  function automatic logic [2:0] m_mode(input int i);
    if (i < 16)  return 3'd0;
    if (i == 16) return 3'd1;
    if (i < 20)  return 3'd2;
    return 3'd3;
  endfunction

  function automatic logic [3:0] m_sel(input int i);
    if (i < 16)  return 4'(i);
    if (i == 16) return 4'd0;
    if (i < 20)  return 4'(i - 16);
    return 4'(i - 6);
  endfunction

  function automatic logic [31:0] m_data(input int i);
    if (pat_sel == 0) return obs_fixed;
    if (pat_sel == 1) return {25'd0, m_mode(i), m_sel(i)};
    return (i == 0) ? 32'hA5 : 32'h0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push_scan();
    exp_t e;
    e.data = m_data(m_idx);
    e.mode = m_mode(m_idx);
    e.sel  = m_sel(m_idx);
    e.done = (m_idx == 21);
    if (e.done) begin
      m_sum = m_acc ^ e.data;
      m_acc = 32'h0;
      m_idx = 0;
    end else begin
      m_acc = m_acc ^ e.data;
      m_idx = m_idx + 1;
    end
    e.sum = CK ? m_sum : 32'h0;
    sb.push_back(e);
  endtask

  task automatic push_manual(input logic [31:0] d, input logic [2:0] m, input logic [3:0] s);
    exp_t e;
    e.data = d;
    e.mode = m;
    e.sel  = s;
    e.done = 1'b0;
    e.sum  = CK ? m_sum : 32'h0;
    sb.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (snap_valid_o === 1'b1) begin
      n_cap++;
      cap_cyc = cyc;
      chk("capture_expected", (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("snap_data", snap_data_o, e.data);
        chk("snap_mode", 32'(snap_mode_o), 32'(e.mode));
        chk("snap_sel", 32'(snap_sel_o), 32'(e.sel));
        chk("sweep_done", 32'(sweep_done_o), 32'(e.done));
        chk("sweep_sum", sweep_sum_o, e.sum);
      end
    end else begin
      chk("sweep_done_without_valid", 32'(sweep_done_o), 32'd0);
    end
  endtask

  task automatic press(input int n);
    step_i = 1'b1;
    repeat (n) tick();
    step_i = 1'b0;
  endtask

  task automatic wait_cap(input int budget, input string tag);
    int c0;
    int k;
    c0 = n_cap;
    k  = 0;
    while (n_cap == c0 && k < budget) begin
      tick();
      k++;
    end
    chk({tag, "_capture_arrived"}, (n_cap != c0) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic run_sweep(input string tag);
    for (int i = 0; i < 22; i++) push_scan();
    for (int i = 0; i < 22; i++) begin
      wait_cap(12, tag);
      if (last_cap >= 0) chk({tag, "_period"}, 32'(cap_cyc - last_cap), 32'd8);
      last_cap = cap_cyc;
    end
    chk({tag, "_idx_wrapped"}, 32'(scan_idx_o), 32'd0);
    chk({tag, "_queue_empty"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    manual_i   = 1'b0;
    run_i      = 1'b0;
    step_i     = 1'b0;
    mode_req_i = 3'd0;
    sel_req_i  = 4'd0;
    pat_sel    = 0;
    obs_fixed  = 32'h0;

    // Reset and idle quietly.
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (20) tick();
    chk("rst_snap_data", snap_data_o, 32'h0);
    chk("rst_snap_mode", 32'(snap_mode_o), 32'd0);
    chk("rst_snap_sel", 32'(snap_sel_o), 32'd0);
    chk("rst_snap_valid", 32'(snap_valid_o), 32'd0);
    chk("rst_obs_mode", 32'(obs_mode_o), 32'd0);
    chk("rst_obs_sel", 32'(obs_sel_o), 32'd0);
    chk("rst_scan_idx", 32'(scan_idx_o), 32'd0);
    chk("rst_sweep_sum", sweep_sum_o, 32'h0);

    // Manual capture.
    manual_i   = 1'b1;
    mode_req_i = 3'd3;
    sel_req_i  = 4'd14;
    obs_fixed  = 32'h0000_0040;
    push_manual(32'h40, 3'd3, 4'd14);
    press(3);
    wait_cap(20, "manual");
    repeat (20) tick();
    chk("manual_idx_unchanged", 32'(scan_idx_o), 32'd0);
    chk("manual_obs_sel_hold", 32'(obs_sel_o), 32'd14);
    chk("manual_single_capture", 32'(sb.size()), 32'd0);

    // Scan with single steps: a long press gives exactly one capture.
    manual_i = 1'b0;
    run_i    = 1'b0;
    pat_sel  = 1;
    push_scan();
    press(100);
    repeat (5) tick();
    chk("step_hold_one_capture", 32'(sb.size()), 32'd0);
    chk("step_hold_idx", 32'(scan_idx_o), 32'd1);
    push_scan();
    press(3);
    wait_cap(20, "step2");
    push_scan();
    press(3);
    wait_cap(20, "step3");
    repeat (5) tick();
    chk("three_steps_idx", 32'(scan_idx_o), 32'd3);

    // Manual capture with idx nonzero leaves idx alone.
    manual_i   = 1'b1;
    mode_req_i = 3'd5;
    sel_req_i  = 4'd9;
    pat_sel    = 0;
    obs_fixed  = 32'hDEAD_BEEF;
    push_manual(32'hDEAD_BEEF, 3'd5, 4'd9);
    press(3);
    wait_cap(20, "manual2");
    repeat (3) tick();
    chk("manual2_idx_unchanged", 32'(scan_idx_o), 32'd3);
    chk("manual2_obs_mode", 32'(obs_mode_o), 32'd5);

    // Start auto-scan, then abort with reset in SETTLE.
    manual_i = 1'b0;
    run_i    = 1'b1;
    pat_sel  = 1;
    tick();
    chk("abort_settle_sel", 32'(obs_sel_o), 32'd3);
    rst_n = 1'b0;
    #2;
    chk("abort_obs_sel", 32'(obs_sel_o), 32'd0);
    chk("abort_snap_data", snap_data_o, 32'h0);
    chk("abort_snap_valid", 32'(snap_valid_o), 32'd0);
    chk("abort_scan_idx", 32'(scan_idx_o), 32'd0);
    rst_n = 1'b1;
    m_idx    = 0;
    m_acc    = 32'h0;
    m_sum    = 32'h0;
    last_cap = -1;

    // Three continuous sweeps with different observer data.
    run_sweep("sweep_pattern");
    pat_sel   = 0;
    obs_fixed = 32'h1;
    run_sweep("sweep_ones");
    chk("sum_all_ones", sweep_sum_o, 32'h0);
    pat_sel = 2;
    run_sweep("sweep_a5");
    chk("sum_a5", sweep_sum_o, CK ? 32'hA5 : 32'h0);

    // Drop run in DWELL together with a step: only an immediate return to IDLE
    // lets that step edge be accepted.
    run_i = 1'b0;
    push_scan();
    press(3);
    wait_cap(20, "run_drop_step");
    repeat (40) tick();
    chk("run_drop_no_more_captures", 32'(sb.size()), 32'd0);
    chk("run_drop_idx", 32'(scan_idx_o), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
